// File: rtl/keygen_defs.sv
// rtl/keygen_defs.sv - shared definitions for the key-pair generator
// Purpose: FSM state encoding, widths, key/hash constants and the Galois LFSR
//          step used by both the generator and its bench model.
// Ports:   none (package).
package keygen_defs;

    localparam int KEY_W   = 8;
    localparam int TABLE_W = 288;

    localparam logic [KEY_W-1:0] LFSR_TAPS_DEFAULT = 8'hB8;
    localparam logic [KEY_W-1:0] NULL_KEY          = 8'h00;
    localparam logic [2:0]       HASH_DONE_CNT     = 3'b111;
    // Last allowed HASH cycle index; a hash still busy here is treated as a reject.
    localparam logic [3:0]       HASH_TIMEOUT      = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STEP  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_HASH  = 3'd3,
        ST_CHECK = 3'd4
    } state_e;

    // One Galois step: shift right, fold the taps in when a 1 falls out.
    function automatic logic [KEY_W-1:0] lfsr_step(input logic [KEY_W-1:0] value,
                                                   input logic [KEY_W-1:0] taps);
        return value[0] ? ((value >> 1) ^ taps) : (value >> 1);
    endfunction

endpackage

// File: rtl/pearson_hash8.sv
// rtl/pearson_hash8.sv - 8-bit Pearson-style hash over a 32-entry table
// Purpose: hashes an 8-bit message in seven table rounds, one per clock after
//          reset_n is released; counter reaches 3'b111 when hash is final.
// Ports:   clk          - clock
//          reset_n      - synchronous active-low restart (loads message)
//          message      - byte to hash, held stable while running
//          random_table - 32 x 9-bit entries: [7:0] value, [8] rotate-left flag
//          hash         - current hash state
//          counter      - rounds completed, saturates at 7
module pearson_hash8 (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   message,
    input  logic [287:0] random_table,
    output logic [7:0]   hash,
    output logic [2:0]   counter
);

    logic [7:0] h_q;
    logic [2:0] cnt_q;
    logic [7:0] mix;
    logic [4:0] idx;
    logic [8:0] entry;

    always_comb begin
        mix   = h_q ^ message;
        // Fold the low three bits into the index so every message bit matters.
        idx   = mix[7:3] ^ {2'b00, mix[2:0]};
        entry = random_table[9*int'(idx) +: 9];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_q   <= message;
            cnt_q <= 3'd0;
        end else if (cnt_q != 3'b111) begin
            h_q   <= entry[8] ? {entry[6:0], entry[7]} : entry[7:0];
            cnt_q <= cnt_q + 3'd1;
        end
    end

    assign hash    = h_q;
    assign counter = cnt_q;

endmodule

// File: rtl/generate_key.sv
// rtl/generate_key.sv - key-pair generator (LFSR private key + Pearson public key)
// Purpose: steps an LFSR from a seed to private-key candidates, hashes each one,
//          and returns the first pair with neither key zero, or fails after
//          MAX_TRIES candidates.
// Ports:   clock, reset        - clock, synchronous active-high reset
//          start, seed         - request and LFSR seed (taken only in IDLE)
//          random_table        - hash permutation table, passed to the hash
//          busy                - run in progress
//          done, fail          - one-cycle result pulses
//          private_key/public_key - accepted pair, held until next start
//          tries               - candidates evaluated in current/last run
module generate_key
    import keygen_defs::*;
#(
    parameter int               MAX_TRIES = 16,
    parameter logic [KEY_W-1:0] LFSR_TAPS = LFSR_TAPS_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [KEY_W-1:0]   seed,
    input  logic [TABLE_W-1:0] random_table,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [KEY_W-1:0]   private_key,
    output logic [KEY_W-1:0]   public_key,
    output logic [4:0]         tries
);

    state_e state_q, state_d;

    logic [KEY_W-1:0] lfsr_q, lfsr_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic [KEY_W-1:0] cand_pub_q, cand_pub_d;
    logic [KEY_W-1:0] priv_q, priv_d;
    logic [KEY_W-1:0] pub_q, pub_d;
    logic [4:0]       tries_q, tries_d;
    logic [3:0]       wait_q, wait_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;

    logic             hash_rst_n;
    logic [KEY_W-1:0] hash_val;
    logic [2:0]       hash_cnt;
    logic             hash_ready;
    logic             hash_timeout;
    logic             accept;
    logic             last_try;
    logic [KEY_W-1:0] lfsr_next;

    assign hash_ready   = (hash_cnt == HASH_DONE_CNT);
    assign hash_timeout = (wait_q == HASH_TIMEOUT);
    assign accept       = (cand_q != NULL_KEY) && (cand_pub_q != NULL_KEY);
    assign last_try     = (tries_q == 5'(MAX_TRIES));
    assign lfsr_next    = lfsr_step(lfsr_q, LFSR_TAPS);

    pearson_hash8 u_hash (
        .clk          (clock),
        .reset_n      (hash_rst_n),
        .message      (cand_q),
        .random_table (random_table),
        .hash         (hash_val),
        .counter      (hash_cnt)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_STEP;
            ST_STEP:  state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_HASH;
            ST_HASH:  if (hash_ready || hash_timeout) state_d = ST_CHECK;
            ST_CHECK: begin
                if (accept || last_try) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STEP;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the hash only runs while in HASH; LOAD holds it in restart
    // so it captures the fresh candidate.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        hash_rst_n = !reset && (state_q == ST_HASH);
    end

    // Datapath next-state
    always_comb begin
        lfsr_d     = lfsr_q;
        cand_d     = cand_q;
        cand_pub_d = cand_pub_q;
        priv_d     = priv_q;
        pub_d      = pub_q;
        tries_d    = tries_q;
        wait_d     = wait_q;
        done_d     = 1'b0;
        fail_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A zero seed would lock the LFSR at zero forever.
                    lfsr_d  = (seed == NULL_KEY) ? 8'h01 : seed;
                    tries_d = 5'd0;
                    priv_d  = NULL_KEY;
                    pub_d   = NULL_KEY;
                end
            end
            ST_STEP: begin
                lfsr_d  = lfsr_next;
                cand_d  = lfsr_next;
                tries_d = tries_q + 5'd1;
            end
            ST_LOAD: begin
                wait_d = 4'd0;
            end
            ST_HASH: begin
                wait_d = wait_q + 4'd1;
                if (hash_ready) begin
                    cand_pub_d = hash_val;
                end else if (hash_timeout) begin
                    cand_pub_d = NULL_KEY;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    priv_d = cand_q;
                    pub_d  = cand_pub_q;
                    done_d = 1'b1;
                end else if (last_try) begin
                    fail_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q     <= 8'h01;
            cand_q     <= NULL_KEY;
            cand_pub_q <= NULL_KEY;
            priv_q     <= NULL_KEY;
            pub_q      <= NULL_KEY;
            tries_q    <= 5'd0;
            wait_q     <= 4'd0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            cand_q     <= cand_d;
            cand_pub_q <= cand_pub_d;
            priv_q     <= priv_d;
            pub_q      <= pub_d;
            tries_q    <= tries_d;
            wait_q     <= wait_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
        end
    end

    assign done        = done_q;
    assign fail        = fail_q;
    assign private_key = priv_q;
    assign public_key  = pub_q;
    assign tries       = tries_q;

endmodule
